// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control path: FSM states, opcodes, funct codes,
// ALU operations and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_SLT    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/alu_funct_decoder.sv
// R-type funct to ALU operation, purely combinational; valid=0 flags an
// unsupported funct. Also used by the single-cycle control path.
module alu_funct_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-memory MIPS datapath; 3-5 cycles per instruction.
// Memory states hold until mem_ready; a watchdog aborts a stalled access via BOOT.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int ALU_OP_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instruction,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                immediate_shifter,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [3:0]          state_o
);

  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;
  localparam bit WD_EN = (WAIT_LIMIT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_wait;
  alu_op_e          alu_sel;
  alu_op_e          funct_op;
  logic             funct_vld;
  logic [5:0]       opcode;
  logic             unused_instr;

  assign opcode       = instruction[31:26];
  assign unused_instr = ^instruction[25:6];
  assign alu_op       = ALU_OP_W'(alu_sel);
  assign state_o      = state_q;

  alu_funct_decoder u_funct_dec (
    .funct  (instruction[5:0]),
    .alu_op (funct_op),
    .valid  (funct_vld)
  );

  always_comb begin
    state_d           = state_q;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    i_or_d            = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_source         = PCSRC_ALU;
    alu_src_a         = 1'b0;
    alu_src_b         = SRCB_REGB;
    alu_sel           = ALU_ADD;
    immediate_shifter = 1'b0;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    reg_write         = 1'b0;
    instr_done        = 1'b0;
    illegal_op        = 1'b0;
    bus_error         = 1'b0;
    mem_wait          = 1'b0;

    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else           mem_wait = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:        state_d = S_R_EXEC;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_ADDI, OP_LUI: state_d = S_I_EXEC;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
        else           mem_wait = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_sel   = funct_op;
        state_d   = funct_vld ? S_R_WB : S_ILLEGAL;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LUI) begin
          alu_sel           = ALU_PASS_B;
          immediate_shifter = 1'b1;
        end
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write         = 1'b1;
        instr_done        = 1'b1;
        immediate_shifter = (opcode == OP_LUI);
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REGB;
        alu_sel    = ALU_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      // PC was already advanced in FETCH, so just resume fetching.
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_BOOT;
    endcase

    // A completing access never reaches here since mem_wait is only set without mem_ready.
    if (WD_EN && mem_wait && (wait_cnt_q == CNT_LAST)) begin
      bus_error = 1'b1;
      state_d   = S_BOOT;
    end

    if (state_d != state_q) wait_cnt_d = '0;
    else if (mem_wait)      wait_cnt_d = wait_cnt_q + 1'b1;
    else                    wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
